// File: rtl/alu_pkg.sv
// Shared constants for the ALU-control decode and the memory-access stage.
// ALU operation codes, ALUOp encodings and the LEGv8 opcodes that are decoded.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_INV   = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_CB  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_e;

  // R-type opcodes are matched on all 11 bits.
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_NOR = 11'b11101010000;

  // I-type opcodes are only 10 bits wide, so they are matched on opcode[10:1].
  localparam logic [9:0] OP_ADDI = 10'b1001000100;
  localparam logic [9:0] OP_SUBI = 10'b1101000100;
  localparam logic [9:0] OP_ANDI = 10'b1001001000;
  localparam logic [9:0] OP_ORRI = 10'b1011001000;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU-control decode: {alu_op, opcode} -> 4-bit ALU operation.
// Optional macro ALU_NOR_EN adds the R-type NOR opcode.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [10:0] opcode,
  input  logic [1:0]  alu_op,
  output logic [3:0]  alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_INV;
    case (alu_op)
      ALUOP_MEM: alu_ctrl = ALU_ADD;
      ALUOP_CB:  alu_ctrl = ALU_PASSB;
      ALUOP_R: begin
        case (opcode)
          OP_ADD:  alu_ctrl = ALU_ADD;
          OP_SUB:  alu_ctrl = ALU_SUB;
          OP_AND:  alu_ctrl = ALU_AND;
          OP_ORR:  alu_ctrl = ALU_OR;
`ifdef ALU_NOR_EN
          OP_NOR:  alu_ctrl = ALU_NOR;
`endif
          default: alu_ctrl = ALU_INV;
        endcase
      end
      ALUOP_I: begin
        case (opcode[10:1])
          OP_ADDI: alu_ctrl = ALU_ADD;
          OP_SUBI: alu_ctrl = ALU_SUB;
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORRI: alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_INV;
        endcase
      end
      default: alu_ctrl = ALU_INV;
    endcase
  end

endmodule

// File: rtl/alu_control_memory_access.sv
// Execute-stage ALU-control decode plus the registered memory-access stage with its data memory.
// Optional macro ALU_NOR_EN enables NOR decode in alu_ctrl_dec.
module alu_control_memory_access
  import alu_pkg::*;
#(
  parameter int DMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  input  logic [1:0]  alu_op,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] instruction,
  input  logic [63:0] branch_addr,
  input  logic [63:0] alu_result,
  input  logic [63:0] data2,
  input  logic        zero,
  input  logic        b,
  input  logic        bz,
  input  logic        bnz,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  output logic [63:0] old_branch_addr,
  output logic        pc_src,
  output logic        old_reg_write,
  output logic [63:0] data2_write,
  output logic [4:0]  reg2_write
);

  localparam int IDX_W = $clog2(DMEM_WORDS);

  alu_ctrl_dec u_dec (
    .opcode   (opcode),
    .alu_op   (alu_op),
    .alu_ctrl (alu_ctrl)
  );

  logic [63:0]      dmem [DMEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic             taken;
  logic             unused_bits;

  // Byte address -> word index; low 3 bits and everything above the array wrap away.
  assign idx         = alu_result[IDX_W+2:3];
  assign taken       = b | (bz & zero) | (bnz & ~zero);
  assign unused_bits = ^{instruction[31:5], alu_result[63:IDX_W+3], alu_result[2:0]};

  // No handshake: every un-reset posedge captures one instruction, results appear next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      old_branch_addr <= '0;
      pc_src          <= 1'b0;
      old_reg_write   <= 1'b0;
      data2_write     <= '0;
      reg2_write      <= '0;
    end else begin
      old_branch_addr <= branch_addr;
      pc_src          <= taken;
      old_reg_write   <= reg_write;
      reg2_write      <= instruction[4:0];
      data2_write     <= mem_to_reg ? (mem_read ? dmem[idx] : 64'd0) : alu_result;
    end
  end

  // Kept separate from the output registers so reset never clears memory contents.
  always_ff @(posedge clk) begin
    if (rst_n && mem_write) begin
      dmem[idx] <= data2;
    end
  end

endmodule

// File: tb/tb_alu_control_memory_access.sv
// Self-checking bench for alu_control_memory_access: decode table, directed sequences and
// randomized transactions checked against a word-array memory model.
module tb_alu_control_memory_access;

  localparam int DMEM_WORDS = 128;

  logic        clk;
  logic        rst_n;
  logic [10:0] opcode;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctrl;
  logic [31:0] instruction;
  logic [63:0] branch_addr;
  logic [63:0] alu_result;
  logic [63:0] data2;
  logic        zero, b, bz, bnz, mem_read, mem_write, mem_to_reg, reg_write;
  logic [63:0] old_branch_addr;
  logic        pc_src;
  logic        old_reg_write;
  logic [63:0] data2_write;
  logic [4:0]  reg2_write;

  alu_control_memory_access #(.DMEM_WORDS(DMEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_op(alu_op), .alu_ctrl(alu_ctrl),
    .instruction(instruction), .branch_addr(branch_addr), .alu_result(alu_result),
    .data2(data2), .zero(zero), .b(b), .bz(bz), .bnz(bnz), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .old_branch_addr(old_branch_addr), .pc_src(pc_src), .old_reg_write(old_reg_write),
    .data2_write(data2_write), .reg2_write(reg2_write)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  op;
    logic [10:0] opc;
    logic [3:0]  exp;
    string       name;
  } dec_vec_t;

  typedef struct {
    logic [31:0] instruction;
    logic [63:0] branch_addr;
    logic [63:0] alu_result;
    logic [63:0] data2;
    logic        zero, b, bz, bnz, mem_read, mem_write, mem_to_reg, reg_write;
  } txn_t;

  logic [63:0] mem_model [DMEM_WORDS];
  logic [63:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference decode written straight from the opcode table.
  function automatic logic [3:0] dec_model(input logic [1:0] op, input logic [10:0] opc);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd7;
    if (op == 2'd2) begin
      if (opc == 11'b10001011000) return 4'd2;
      if (opc == 11'b11001011000) return 4'd6;
      if (opc == 11'b10001010000) return 4'd0;
      if (opc == 11'b10101010000) return 4'd1;
`ifdef ALU_NOR_EN
      if (opc == 11'b11101010000) return 4'd12;
`endif
      return 4'd15;
    end
    if (opc[10:1] == 10'b1001000100) return 4'd2;
    if (opc[10:1] == 10'b1101000100) return 4'd6;
    if (opc[10:1] == 10'b1001001000) return 4'd0;
    if (opc[10:1] == 10'b1011001000) return 4'd1;
    return 4'd15;
  endfunction

  // driver
  task automatic drive(input txn_t t);
    instruction = t.instruction;
    branch_addr = t.branch_addr;
    alu_result  = t.alu_result;
    data2       = t.data2;
    zero        = t.zero;
    b           = t.b;
    bz          = t.bz;
    bnz         = t.bnz;
    mem_read    = t.mem_read;
    mem_write   = t.mem_write;
    mem_to_reg  = t.mem_to_reg;
    reg_write   = t.reg_write;
  endtask

  function automatic txn_t idle_txn();
    txn_t t;
    t.instruction = '0; t.branch_addr = '0; t.alu_result = '0; t.data2 = '0;
    t.zero = 0; t.b = 0; t.bz = 0; t.bnz = 0;
    t.mem_read = 0; t.mem_write = 0; t.mem_to_reg = 0; t.reg_write = 0;
    return t;
  endfunction

  // One instruction through the stage: called at a negedge, returns at the next negedge.
  task automatic step(input txn_t t, input string tag);
    int          wi;
    logic [63:0] e_data;
    logic        e_pc;
    drive(t);
    wi   = int'((t.alu_result / 64'd8) % 64'(DMEM_WORDS));
    e_pc = t.b || (t.bz && t.zero) || (t.bnz && !t.zero);
    if (!t.mem_to_reg)    e_data = t.alu_result;
    else if (t.mem_read)  e_data = mem_model[wi];
    else                  e_data = 64'd0;
    exp_q.push_back(e_data);
    @(negedge clk);
    chk({tag, ".data2_write"}, data2_write, exp_q.pop_front());
    chk({tag, ".pc_src"}, 64'(pc_src), 64'(e_pc));
    chk({tag, ".old_branch_addr"}, old_branch_addr, t.branch_addr);
    chk({tag, ".old_reg_write"}, 64'(old_reg_write), 64'(t.reg_write));
    chk({tag, ".reg2_write"}, 64'(reg2_write), 64'(t.instruction[4:0]));
    if (t.mem_write) mem_model[wi] = t.data2;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ".data2_write"}, data2_write, 64'd0);
    chk({tag, ".pc_src"}, 64'(pc_src), 64'd0);
    chk({tag, ".old_branch_addr"}, old_branch_addr, 64'd0);
    chk({tag, ".old_reg_write"}, 64'(old_reg_write), 64'd0);
    chk({tag, ".reg2_write"}, 64'(reg2_write), 64'd0);
  endtask

  dec_vec_t dec_tab [$];
  txn_t     t;
  logic [1:0]  r_op;
  logic [10:0] r_opc;

  initial begin
    rst_n  = 1'b0;
    opcode = '0;
    alu_op = '0;
    drive(idle_txn());
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset_init");

    // decode table
    dec_tab.push_back('{2'b00, 11'h7FF, 4'b0010, "dec_ldst"});
    dec_tab.push_back('{2'b01, 11'h123, 4'b0111, "dec_cb"});
    dec_tab.push_back('{2'b10, 11'b10001011000, 4'b0010, "dec_add"});
    dec_tab.push_back('{2'b10, 11'b11001011000, 4'b0110, "dec_sub"});
    dec_tab.push_back('{2'b10, 11'b10001010000, 4'b0000, "dec_and"});
    dec_tab.push_back('{2'b10, 11'b10101010000, 4'b0001, "dec_orr"});
    dec_tab.push_back('{2'b11, 11'b10010001000, 4'b0010, "dec_addi"});
    dec_tab.push_back('{2'b11, 11'b10010001001, 4'b0010, "dec_addi_b0"});
    dec_tab.push_back('{2'b11, 11'b11010001000, 4'b0110, "dec_subi"});
    dec_tab.push_back('{2'b11, 11'b10010010001, 4'b0000, "dec_andi"});
    dec_tab.push_back('{2'b11, 11'b10110010000, 4'b0001, "dec_orri"});
    dec_tab.push_back('{2'b10, 11'd0, 4'b1111, "dec_r_zero"});
    dec_tab.push_back('{2'b11, 11'd0, 4'b1111, "dec_i_zero"});
    dec_tab.push_back('{2'b10, 11'b10001011001, 4'b1111, "dec_r_add_b0"});
`ifdef ALU_NOR_EN
    dec_tab.push_back('{2'b10, 11'b11101010000, 4'b1100, "dec_nor"});
`else
    dec_tab.push_back('{2'b10, 11'b11101010000, 4'b1111, "dec_nor_off"});
`endif
    foreach (dec_tab[i]) begin
      alu_op = dec_tab[i].op;
      opcode = dec_tab[i].opc;
      #1;
      chk(dec_tab[i].name, 64'(alu_ctrl), 64'(dec_tab[i].exp));
    end
    for (int i = 0; i < 60; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_opc = 11'($urandom);
      if (i % 2 == 0) begin
        // bias toward real opcodes, keeping bit 0 random for I-type
        case ($urandom_range(0, 4))
          0: r_opc = 11'b10001011000;
          1: r_opc = 11'b11001011000;
          2: r_opc = {10'b1001001000, r_opc[0]};
          3: r_opc = {10'b1011001000, r_opc[0]};
          default: r_opc = 11'b11101010000;
        endcase
      end
      alu_op = r_op;
      opcode = r_opc;
      #1;
      chk("dec_rand", 64'(alu_ctrl), 64'(dec_model(r_op, r_opc)));
    end

    @(negedge clk);
    rst_n = 1'b1;

    // fill memory through the store path so every word has a known value
    for (int i = 0; i < DMEM_WORDS; i++) begin
      t = idle_txn();
      t.mem_write  = 1'b1;
      t.alu_result = 64'(i) * 64'd8;
      t.data2      = {$urandom, $urandom};
      step(t, "fill");
    end

    // branch: CBZ taken, then CBNZ with zero set not taken
    t = idle_txn(); t.bz = 1; t.zero = 1; t.branch_addr = 64'h100;
    step(t, "cbz_taken");
    t = idle_txn(); t.bnz = 1; t.zero = 1; t.branch_addr = 64'h200;
    step(t, "cbnz_not_taken");

    // store then load
    t = idle_txn(); t.mem_write = 1; t.alu_result = 64'h18; t.data2 = 64'hDEAD;
    step(t, "store_18");
    t = idle_txn(); t.mem_read = 1; t.mem_to_reg = 1; t.reg_write = 1;
    t.alu_result = 64'h18; t.instruction = 32'h0000_0013;
    step(t, "load_18");
    chk("load_18.literal", data2_write, 64'hDEAD);

    // R-type write-back
    t = idle_txn(); t.alu_result = 64'd42; t.reg_write = 1; t.instruction = 32'h8B00_0009;
    step(t, "rtype");
    chk("rtype.literal", data2_write, 64'd42);

    // same-cycle read and write returns old data, then new data
    t = idle_txn(); t.mem_read = 1; t.mem_to_reg = 1; t.mem_write = 1;
    t.alu_result = 64'h18; t.data2 = 64'hBEEF;
    step(t, "rw_same");
    chk("rw_same.old", data2_write, 64'hDEAD);
    t = idle_txn(); t.mem_read = 1; t.mem_to_reg = 1; t.alu_result = 64'h1F;
    step(t, "rw_after");
    chk("rw_after.new", data2_write, 64'hBEEF);

    // wrap: store beyond the array, load at 8
    t = idle_txn(); t.mem_write = 1; t.alu_result = 64'(DMEM_WORDS * 8 + 8);
    t.data2 = 64'hCAFE_F00D_1234_5678;
    step(t, "wrap_store");
    t = idle_txn(); t.mem_read = 1; t.mem_to_reg = 1; t.alu_result = 64'd8;
    step(t, "wrap_load");
    chk("wrap_load.literal", data2_write, 64'hCAFE_F00D_1234_5678);

    // mem_to_reg without mem_read gives zero
    t = idle_txn(); t.mem_to_reg = 1; t.alu_result = 64'd8;
    step(t, "m2r_no_read");

    // reset with every input high: outputs clear, the store to the top word is dropped
    t = idle_txn(); t.mem_write = 1; t.alu_result = 64'hFFFF_FFFF_FFFF_FFF8; t.data2 = 64'h1234;
    step(t, "pre_reset_store");
    t.instruction = '1; t.branch_addr = '1; t.alu_result = '1; t.data2 = '1;
    t.zero = 1; t.b = 1; t.bz = 1; t.bnz = 1;
    t.mem_read = 1; t.mem_write = 1; t.mem_to_reg = 1; t.reg_write = 1;
    drive(t);
    rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset_mid");
    rst_n = 1'b1;
    t = idle_txn(); t.mem_read = 1; t.mem_to_reg = 1; t.alu_result = 64'hFFFF_FFFF_FFFF_FFF8;
    step(t, "post_reset_load");
    chk("post_reset_load.literal", data2_write, 64'h1234);

    // randomized transactions against the model
    for (int i = 0; i < 300; i++) begin
      t.instruction = $urandom;
      t.branch_addr = {$urandom, $urandom};
      t.alu_result  = {$urandom, $urandom};
      t.data2       = {$urandom, $urandom};
      t.zero        = 1'($urandom_range(0, 1));
      t.b           = ($urandom_range(0, 3) == 0);
      t.bz          = 1'($urandom_range(0, 1));
      t.bnz         = 1'($urandom_range(0, 1));
      t.mem_read    = 1'($urandom_range(0, 1));
      t.mem_write   = 1'($urandom_range(0, 1));
      t.mem_to_reg  = 1'($urandom_range(0, 1));
      t.reg_write   = 1'($urandom_range(0, 1));
      if (i % 3 == 0) t.alu_result[63:10] = '0;
      step(t, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
